// File: rtl/fifo_stream_drain.sv
// fifo_stream_drain: read-side drain stage for the synchronous FIFO.
// Issues FIFO read strobes, captures returned words on the read-done pulse
// and presents them on a valid/ready stream through a 2-entry buffer.
// Optional packet framing on o_m_last is compiled in with `define PKT_LAST_EN.
module fifo_stream_drain #(
  parameter int G_WIDTH   = 8,
  parameter int G_PKT_LEN = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_fifo_empty,
  input  logic [G_WIDTH-1:0] i_fifo_data,
  input  logic               i_fifo_rd_done,
  output logic               o_fifo_rd,
  output logic               o_m_valid,
  input  logic               i_m_ready,
  output logic [G_WIDTH-1:0] o_m_data,
  output logic               o_m_last,
  output logic               o_err
);

  logic               r_run;
  logic               r_pending;
  logic               r_err;
  logic [1:0]         r_count;
  logic               r_head;
  logic               r_tail;
  logic [G_WIDTH-1:0] r_buf [2];

  logic               w_pop;
  logic               w_cap;
  logic               w_overrun;
  logic               w_err_evt;
  logic [2:0]         w_level;

  // A beat leaves the buffer whenever the sink accepts the head entry.
  assign w_pop = o_m_valid && i_m_ready;

  // Occupancy the buffer will have once the outstanding read lands and this
  // cycle's pop retires; a new read is allowed only if that leaves a slot.
  assign w_level   = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
  assign o_fifo_rd = r_run && !i_fifo_empty && (w_level < 3'd2);

  // A done pulse with no free slot is dropped; a pulse before the block is
  // running (first cycle after reset release) is also ignored.
  assign w_overrun = i_fifo_rd_done && (r_count == 2'd2) && !w_pop;
  assign w_cap     = i_fifo_rd_done && r_run && !w_overrun;

  // Refused read, unsolicited data, or buffer overrun.
  assign w_err_evt = (r_pending && !i_fifo_rd_done)
                   || (i_fifo_rd_done && !r_pending)
                   || w_overrun;

  assign o_m_valid = (r_count != 2'd0);
  assign o_m_data  = r_buf[r_head];
  assign o_err     = r_err;

  // Run enable, read-in-flight flag and sticky error flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run     <= 1'b0;
      r_pending <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_pending <= o_fifo_rd;
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  // Buffer pointers and occupancy; capture and pop together keep the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_cap) begin
        r_tail <= ~r_tail;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_cap && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_cap && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  // Buffer storage: returned FIFO word is written at the tail slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_cap) begin
      r_buf[r_tail] <= i_fifo_data;
    end
  end

`ifdef PKT_LAST_EN
  localparam int LP_BEAT_W = (G_PKT_LEN > 1) ? $clog2(G_PKT_LEN) : 1;
  localparam logic [LP_BEAT_W-1:0] LP_LAST_BEAT = LP_BEAT_W'(G_PKT_LEN - 1);

  logic [LP_BEAT_W-1:0] r_beat;

  // Beat position within the packet, advanced on every accepted beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat <= '0;
    end else if (w_pop) begin
      if (r_beat == LP_LAST_BEAT) begin
        r_beat <= '0;
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  assign o_m_last = o_m_valid && (r_beat == LP_LAST_BEAT);
`else
  // Framing not built: last never asserts, whatever the packet length.
  assign o_m_last = (G_PKT_LEN < 1) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// tb_fifo_stream_drain: directed sequence with random data against a
// queue-based FIFO model and an in-order stream scoreboard.
module tb_fifo_stream_drain;

  localparam int W   = 8;
  localparam int PKT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         empty;
  logic [W-1:0] fdata;
  logic         done;
  logic         ready;
  logic         o_fifo_rd;
  logic         o_m_valid;
  logic [W-1:0] o_m_data;
  logic         o_m_last;
  logic         o_err;

  always #5 clk = ~clk;

  fifo_stream_drain #(.G_WIDTH(W), .G_PKT_LEN(PKT)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_fifo_empty  (empty),
    .i_fifo_data   (fdata),
    .i_fifo_rd_done(done),
    .o_fifo_rd     (o_fifo_rd),
    .o_m_valid     (o_m_valid),
    .i_m_ready     (ready),
    .o_m_data      (o_m_data),
    .o_m_last      (o_m_last),
    .o_err         (o_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] fq[$];     // words still held in the FIFO
  logic [W-1:0] exp_q[$];  // words the stream still owes, in order
  int           pcyc[$];   // cycles in which a beat was accepted
  int           cyc      = 0;
  int           nbeats   = 0;
  int           rd_cnt   = 0;
  int           last_cnt = 0;
  logic         drop_next    = 1'b0;
  logic         err_expected = 1'b0;

  logic         rd_s, v_s, last_s, err_s;
  logic [W-1:0] d_s;
  logic         prev_v = 1'b0;
  logic         prev_r = 1'b0;
  logic [W-1:0] prev_d = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    empty = 1'b0;
  endtask

  // One clock: sample at the falling edge, then play the FIFO's response.
  task automatic tick();
    logic exp_last;
    @(negedge clk);
    cyc++;
    rd_s   = o_fifo_rd;
    v_s    = o_m_valid;
    d_s    = o_m_data;
    last_s = o_m_last;
    err_s  = o_err;
    if (rst_n) begin
      if (prev_v && !prev_r) begin
        check("hold_valid", 32'(v_s), 32'd1);
        check("hold_data", 32'(d_s), 32'(prev_d));
      end
      if (v_s) begin
`ifdef PKT_LAST_EN
        exp_last = ((nbeats % PKT) == PKT - 1);
`else
        exp_last = 1'b0;
`endif
        check("last", 32'(last_s), 32'(exp_last));
      end
      if (v_s && ready) begin
        pcyc.push_back(cyc);
        if (last_s) last_cnt++;
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("beat_data", 32'(d_s), 32'(exp_q.pop_front()));
        nbeats++;
      end
      if (!err_expected) check("err_clear", 32'(err_s), 32'd0);
      if (rd_s) rd_cnt++;
    end
    prev_v = v_s && rst_n;
    prev_r = ready;
    prev_d = d_s;
    @(posedge clk);
    #1;
    if (rd_s) begin
      check("no_over_read", 32'(fq.size() != 0), 32'd1);
      if (fq.size() == 0) begin
        done = 1'b0;
      end else if (drop_next) begin
        void'(fq.pop_front());
        drop_next = 1'b0;
        done = 1'b0;
      end else begin
        fdata = fq.pop_front();
        done  = 1'b1;
      end
    end else begin
      done = 1'b0;
    end
    empty = (fq.size() == 0);
  endtask

  initial begin
    int  c1;
    int  expected_lasts;
    logic found;

    rst_n = 1'b0; empty = 1'b1; done = 1'b0; fdata = '0; ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_rd", 32'(rd_s), 32'd0);
    check("rst_valid", 32'(v_s), 32'd0);
    check("rst_data", 32'(d_s), 32'd0);
    check("rst_last", 32'(last_s), 32'd0);
    check("rst_err", 32'(err_s), 32'd0);

    // Three-word stream straight after reset release, sink always ready
    push(8'h11); push(8'h22); push(8'h33);
    ready = 1'b1;
    tick();
    rst_n = 1'b1;
    pcyc.delete();
    tick();
    check("t1_rd_release_cycle", 32'(rd_s), 32'd0);
    tick();
    c1 = cyc;
    check("t1_first_rd", 32'(rd_s), 32'd1);
    check("t1_valid_early", 32'(v_s), 32'd0);
    tick();
    check("t1_valid_e", 32'(v_s), 32'd0);
    tick();
    check("t1_valid_e1", 32'(v_s), 32'd1);
    repeat (3) tick();
    check("t1_beats", 32'(pcyc.size()), 32'd3);
    if (pcyc.size() == 3) begin
      check("t1_latency", 32'(pcyc[0] - c1), 32'd2);
      check("t1_back_to_back", 32'(pcyc[2] - pcyc[0]), 32'd2);
    end
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: five words, sink stalled for ten cycles
    ready = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    repeat (10) tick();
    check("t2_reads_stalled", 32'(rd_cnt), 32'd2);
    check("t2_valid", 32'(v_s), 32'd1);
    check("t2_head", 32'(d_s), 32'hA0);
    pcyc.delete();
    ready = 1'b1;
    repeat (10) tick();
    check("t2_beats", 32'(pcyc.size()), 32'd5);
    if (pcyc.size() == 5) check("t2_no_gaps", 32'(pcyc[4] - pcyc[0]), 32'd4);
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Alternating ready over sixteen random words
    for (int i = 0; i < 16; i++) push(8'($urandom));
    for (int i = 0; i < 60; i++) begin
      ready = (i % 2 == 0);
      tick();
    end
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Random ready over twenty random words
    for (int i = 0; i < 20; i++) push(8'($urandom));
    for (int i = 0; i < 120; i++) begin
      ready = 1'($urandom_range(0, 1));
      tick();
    end
    ready = 1'b1;
    repeat (6) tick();
    check("t3r_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two words buffered, then eight-beat stream
    ready = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 6; i++) push(8'($urandom));
    repeat (5) tick();
    check("t7_reads", 32'(rd_cnt), 32'd2);
    check("t7_buffered_valid", 32'(v_s), 32'd1);
    rst_n = 1'b0;
    done  = 1'b0;
    #1;
    check("t7_async_valid", 32'(o_m_valid), 32'd0);
    check("t7_async_data", 32'(o_m_data), 32'd0);
    check("t7_async_rd", 32'(o_fifo_rd), 32'd0);
    exp_q  = fq;
    nbeats = 0;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    repeat (2) tick();
    rst_n = 1'b1;
    ready = 1'b1;
    last_cnt = 0;
    pcyc.delete();
    repeat (20) tick();
    check("t7_beats", 32'(pcyc.size()), 32'd8);
    check("t7_drained", 32'(exp_q.size()), 32'd0);
`ifdef PKT_LAST_EN
    expected_lasts = 2;
`else
    expected_lasts = 0;
`endif
    check("t7_last_count", 32'(last_cnt), 32'(expected_lasts));

    // FIFO refuses an issued read
    fq.push_back(8'hEE);
    drop_next = 1'b1;
    empty = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (rd_s) found = 1'b1;
    end
    check("t4_rd_issued", 32'(found), 32'd1);
    tick();
    check("t4_err_refusal_cycle", 32'(err_s), 32'd0);
    err_expected = 1'b1;
    tick();
    check("t4_err_set", 32'(err_s), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_err_sticky", 32'(err_s), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    check("t4_err_reset", 32'(o_err), 32'd0);
    exp_q  = fq;
    nbeats = 0;
    err_expected = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    push(8'h5A);
    repeat (6) tick();
    check("t4_recovered", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
